// File: rtl/pc_pipeline_elastic.sv
// rtl/pc_pipeline_elastic.sv - multi-stage elastic pipeline register with backpressure and flush
//
// Carries a WIDTH-bit payload through DEPTH register stages, each with its
// own valid bit. Empty stages always accept, so gaps between entries close
// up while downstream stalls. A flush kills every in-flight entry at the
// next edge.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   clr        asynchronous active-low reset
//   in_data    payload from upstream
//   in_valid   upstream payload valid
//   in_ready   pipeline accepts in_data this cycle
//   out_data   data of the last stage
//   out_valid  last stage holds valid data (masked by flush)
//   out_ready  downstream accepts out_data this cycle
//   flush      synchronous kill of all in-flight entries
//   occupancy  number of valid stages

module pc_pipeline_elastic #(
  parameter int               WIDTH     = 12,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] inc_valid;
  logic [WIDTH-1:0] inc_data [DEPTH];
  logic             accept;

  // A stage can load when downstream drains or any stage between it and the
  // output is empty. Writing the chain as a reduction over the valid bits
  // keeps it free of bit-to-bit combinational feedback inside rdy.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
      assign rdy[g] = out_ready | ~(&valid_q[DEPTH-1:g]);
    end
  endgenerate

  assign in_ready = rdy[0] & ~flush;
  assign accept   = in_valid & in_ready;

  assign inc_valid[0] = accept;
  assign inc_data[0]  = in_data;

  generate
    for (genvar g = 1; g < DEPTH; g++) begin : g_chain
      assign inc_valid[g] = valid_q[g-1];
      assign inc_data[g]  = data_q[g-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= FLUSH_VAL;
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= FLUSH_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= inc_valid[i];
          // Bubbles moving in leave the old payload in place.
          if (inc_valid[i]) data_q[i] <= inc_data[i];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(valid_q[i]);
  end

endmodule
